// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit (shift-add MULT, restoring DIV) holding HI/LO.
// Optional build macro MULDIV_EARLY_DIV0_EN: a DIV by zero skips CALC/FIX and completes right after LOAD.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       state_dbg
);

  // Handshake: start is a request taken only while busy is low; done is a one-cycle
  // completion pulse and hi/lo are valid from that cycle until the next completion.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;
  logic               sa_q;
  logic               sb_q;
  logic               bz_q;
  logic [WIDTH:0]     mag_a;
  logic [WIDTH:0]     mag_b;
  logic [WIDTH:0]     work_hi;
  logic [WIDTH-1:0]   work_lo;

  logic [WIDTH:0]     mag_a_in;
  logic [WIDTH:0]     mag_b_in;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_trial;
  logic               div_ok;
  logic [WIDTH:0]     div_rem_nx;
  logic [WIDTH-1:0]   div_quot_nx;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   rem_w;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   quot_fix;

  assign state_dbg = state;

  // Magnitudes are one bit wider so the most-negative operand stays representable.
  assign mag_a_in = a[WIDTH-1] ? -{1'b1, a} : {1'b0, a};
  assign mag_b_in = b[WIDTH-1] ? -{1'b1, b} : {1'b0, b};

  assign mul_sum = work_lo[0] ? (work_hi + mag_a) : work_hi;

  assign div_shift   = {work_hi[WIDTH-1:0], work_lo[WIDTH-1]};
  assign div_trial   = {1'b0, div_shift} - {1'b0, mag_b};
  assign div_ok      = ~div_trial[WIDTH+1];
  assign div_rem_nx  = div_ok ? div_trial[WIDTH:0] : div_shift;
  assign div_quot_nx = {work_lo[WIDTH-2:0], div_ok};

  assign prod     = {work_hi[WIDTH-1:0], work_lo};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
  assign rem_w    = work_hi[WIDTH-1:0];
  assign rem_fix  = sa_q ? -rem_w : rem_w;
  assign quot_fix = (sa_q ^ sb_q) ? -work_lo : work_lo;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      work_hi <= '0;
      work_lo <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op_div;
            mag_a <= mag_a_in;
            mag_b <= mag_b_in;
            sa_q  <= a[WIDTH-1];
            sb_q  <= b[WIDTH-1];
            bz_q  <= (b == '0);
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt     <= '0;
          work_hi <= '0;
          work_lo <= op_q ? mag_a[WIDTH-1:0] : mag_b[WIDTH-1:0];
`ifdef MULDIV_EARLY_DIV0_EN
          if (op_q && bz_q) begin
            done  <= 1'b1;
            div0  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_CALC;
          end
`else
          state <= S_CALC;
`endif
        end
        S_CALC: begin
          if (op_q) begin
            work_hi <= div_rem_nx;
            work_lo <= div_quot_nx;
          end else begin
            work_hi <= {1'b0, mul_sum[WIDTH:1]};
            work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) state <= S_FIX;
        end
        S_FIX: begin
          if (!op_q) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (!bz_q) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
          done  <= 1'b1;
          div0  <= op_q && bz_q;
          state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          div0  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          div0  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
